// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch stage.
// Configuration macro: FETCH_MISALIGN_CHECK_EN (see fetch_unit.sv).
package fetch_unit_pkg;

    localparam int          INST_W         = 32;
    localparam int          PC_W           = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC         = 32'd4;
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] word;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-side and decoder-side channels of the fetch stage.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds payload
// stable while valid && !ready. The imem response channel is valid-only (no backpressure).
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from registered storage.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A push into a full FIFO is accepted only when the same cycle pops.
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests to inst_mem, {pc, word} buffer to the decoder,
// and redirect with discard of stale words. Optional FETCH_MISALIGN_CHECK_EN adds misalign_err.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    fetch_unit_if.master      bus,
    input  logic              jump_flag,
    input  logic [31:0]       jump_target
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic              misalign_err
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] buf_count;
    logic [CW:0]   credit_used;
    logic [31:0]   tag_head;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_push;
    logic          halt;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_keep;

    // Requests in flight (including ones to be dropped) plus buffered words never exceed the buffer.
    assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
    assign req_valid   = reset && !halt && !jump_flag && (credit_used < CREDITS);
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign rsp_keep    = bus.imem_rsp_valid && !jump_flag && (drop_cnt == '0) && (tag_count != '0);
    assign buf_push    = '{pc: tag_head, word: bus.imem_rsp_data};

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (buf_count != '0);
    assign bus.inst           = buf_head.word;
    assign bus.inst_pc        = buf_head.pc;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !bus.imem_rsp_valid) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!req_fire && bus.imem_rsp_valid) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    // On a redirect every request still in flight becomes stale; drops already pending are part of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (jump_flag) begin
                drop_cnt <= outstanding_next;
                fetch_pc <= align_pc(jump_target);
            end else begin
                if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_INC;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (jump_flag && (jump_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
    assign halt         = misalign_q;
`else
    assign halt = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (jump_flag),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .head      (tag_head),
        .count     (tag_count)
    );

    // Flush has priority inside the FIFO, so a decoder pop in a redirect cycle is ignored.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (jump_flag),
        .push      (rsp_keep),
        .push_data (buf_push),
        .pop       (bus.inst_ready),
        .head      (buf_head),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with in-order variable latency and an
// epoch-based reference of which fetched words must reach the decoder.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_target = 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    fetch_unit_if bus();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .jump_flag   (jump_flag),
        .jump_target (jump_target)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } req_t;

    req_t        mem_q[$];
    logic [63:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_mode = 0;
    int          inst_mode = 0;
    logic [31:0] exp_pc = FETCH_RESET_PC;
    bit          halted = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit jf, input logic [31:0] jt);
        bit    rsp;
        bit    keep;
        bit    exp_valid;
        req_t  r;
        int    d;
        @(negedge clk);
        cyc++;
        bus.imem_req_ready = (ready_mode == 0) ? 1'b1 :
                             (ready_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        bus.inst_ready     = (inst_mode == 0) ? 1'b1 :
                             (inst_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        jump_flag   = jf;
        jump_target = jt;
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_q[0].data : NOP_INST;
        #1;
        exp_valid = !halted && !jf && (mem_q.size() + exp_q.size() < 2);
        check("req_valid", {63'd0, bus.imem_req_valid}, {63'd0, exp_valid});
        if (exp_valid) check("req_addr", {32'd0, bus.imem_req_addr}, {32'd0, exp_pc});
        check("inst_valid", {63'd0, bus.inst_valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) check("inst_pc_word", {bus.inst_pc, bus.inst}, exp_q[0]);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misalign_err", {63'd0, misalign_err}, {63'd0, halted});
`endif
        keep = 1'b0;
        if (rsp) begin
            r = mem_q.pop_front();
            keep = !jf && (r.epoch == epoch);
        end
        if (!jf && bus.inst_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (keep) exp_q.push_back({r.addr, r.data});
        if (exp_valid && bus.imem_req_ready) begin
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{addr: exp_pc, data: $urandom, epoch: epoch, due: d});
            exp_pc = exp_pc + 32'd4;
        end
        if (jf) begin
            exp_q.delete();
            epoch++;
            exp_pc = {jt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
            if (jt[1:0] != 2'b00) halted = 1'b1;
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        jump_flag = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = NOP_INST;
        mem_q.delete();
        exp_q.delete();
        exp_pc = FETCH_RESET_PC;
        halted = 1'b0;
        #1;
        check("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check("rst_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        check("rst_inst", {32'd0, bus.inst}, 64'd0);
        check("rst_inst_pc", {32'd0, bus.inst_pc}, 64'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", {63'd0, misalign_err}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        bit          found;
        logic [31:0] t;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = NOP_INST;
        #1 reset = 1'b0;
        do_reset();

        // streaming from reset, single-cycle memory
        ready_mode = 0; inst_mode = 0; lat_min = 1; lat_max = 1;
        repeat (12) step(1'b0, 32'h0);

        // decoder stall fills the buffer, then drains in order
        inst_mode = 1;
        repeat (10) step(1'b0, 32'h0);
        inst_mode = 0;
        repeat (10) step(1'b0, 32'h0);

        // redirect with two requests in flight at latency 3
        lat_min = 3; lat_max = 3;
        repeat (4) step(1'b0, 32'h0);
        step(1'b1, 32'h100);
        repeat (15) step(1'b0, 32'h0);

        // redirect coinciding with a response and a decoder pop
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1 && exp_q.size() > 0) begin
                step(1'b1, 32'h200);
                found = 1'b1;
            end else begin
                step(1'b0, 32'h0);
            end
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL coincide_search observed=0 expected=1");
        end
        repeat (10) step(1'b0, 32'h0);

        // request-side stall toggling every cycle
        lat_min = 1; lat_max = 1; ready_mode = 1;
        repeat (30) step(1'b0, 32'h0);
        ready_mode = 0;

        // back-to-back redirects, then 32-bit wrap of the PC
        step(1'b1, 32'h300);
        step(1'b1, 32'h400);
        repeat (8) step(1'b0, 32'h0);
        step(1'b1, 32'hFFFF_FFF4);
        repeat (10) step(1'b0, 32'h0);

        // randomized traffic with redirects and variable latency
        ready_mode = 2; inst_mode = 2; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                t = $urandom;
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0;
                t[1:0] = 2'b00;
                step(1'b1, t);
            end else begin
                step(1'b0, 32'h0);
            end
        end

        // reset in the middle of traffic
        do_reset();
        repeat (20) step(1'b0, 32'h0);

        // misaligned redirect
        ready_mode = 0; inst_mode = 0; lat_min = 1; lat_max = 2;
        repeat (3) step(1'b0, 32'h0);
        step(1'b1, 32'h102);
        repeat (12) step(1'b0, 32'h0);
        do_reset();
        repeat (6) step(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
